// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery / full-flush sequencer for the ROB/rename backend.
// Optional statistics counters are enabled with `define RECOVERY_CTRL_STATS_EN.
module recovery_ctrl #(
    parameter int unsigned ROB_W        = 4,
    parameter int unsigned MAX_CKPT     = 4,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROB_W-1:0] head_tag_i,
    input  logic             br_disp_i,
    input  logic [ROB_W-1:0] br_tag_i,
    output logic             ckpt_take_o,
    output logic [ROB_W-1:0] ckpt_tag_o,
    output logic             dispatch_stall_o,
    input  logic             bru_valid_i,
    input  logic             bru_mispred_i,
    input  logic [ROB_W-1:0] bru_tag_i,
    input  logic             exc_valid_i,
    output logic             recover_o,
    output logic [ROB_W-1:0] recover_tag_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic             busy_o
`ifdef RECOVERY_CTRL_STATS_EN
    ,
    output logic [31:0]      mispred_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    localparam int unsigned DEPTH = 2 ** ROB_W;
    localparam int unsigned CW    = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECOVER,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t             r_state, w_next;
    logic [DEPTH-1:0]   r_live, w_live_nxt;
    logic [ROB_W-1:0]   r_pend_tag, w_pend_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_from_flush, w_from_flush_nxt;
    logic [ROB_W:0]     w_live_cnt;
    logic               w_mispred;
    logic               w_take;

    function automatic logic [ROB_W-1:0] age(input logic [ROB_W-1:0] t,
                                             input logic [ROB_W-1:0] h);
        return t - h;
    endfunction

    always_comb begin
        w_live_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            w_live_cnt = w_live_cnt + (ROB_W + 1)'(r_live[i]);
    end

    assign w_mispred = bru_valid_i && bru_mispred_i;
    // rst_n gates the grant so every pulse output is low while reset is held
    assign w_take    = rst_n && br_disp_i && (r_state == S_IDLE) &&
                       (w_live_cnt < (ROB_W + 1)'(MAX_CKPT)) &&
                       !w_mispred && !exc_valid_i;

    assign ckpt_take_o      = w_take;
    assign ckpt_tag_o       = w_take ? br_tag_i : '0;
    assign dispatch_stall_o = (r_state != S_IDLE) ||
                              (br_disp_i && (w_live_cnt >= (ROB_W + 1)'(MAX_CKPT)));
    assign recover_o        = (r_state == S_RECOVER);
    assign flush_o          = (r_state == S_FLUSH);
    assign redirect_o       = recover_o || flush_o;
    assign recover_tag_o    = r_pend_tag;
    assign busy_o           = (r_state != S_IDLE);

    always_comb begin
        w_next           = r_state;
        w_pend_nxt       = r_pend_tag;
        w_cnt_nxt        = r_cnt;
        w_from_flush_nxt = r_from_flush;
        unique case (r_state)
            S_IDLE: begin
                if (exc_valid_i) begin
                    w_next = S_FLUSH;
                end else if (w_mispred) begin
                    w_next     = S_RECOVER;
                    w_pend_nxt = bru_tag_i;
                end
            end
            S_RECOVER: begin
                w_next           = S_DRAIN;
                w_cnt_nxt        = CW'(STALL_CYCLES);
                w_from_flush_nxt = 1'b0;
            end
            S_FLUSH: begin
                w_next           = S_DRAIN;
                w_cnt_nxt        = CW'(STALL_CYCLES);
                w_from_flush_nxt = 1'b1;
            end
            S_DRAIN: begin
                // after a full flush every in-flight branch is already squashed
                if (exc_valid_i) begin
                    w_next = S_FLUSH;
                end else if (w_mispred && !r_from_flush &&
                             (age(bru_tag_i, head_tag_i) < age(r_pend_tag, head_tag_i))) begin
                    w_next     = S_RECOVER;
                    w_pend_nxt = bru_tag_i;
                end else if (r_cnt <= CW'(1)) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_live_nxt = r_live;
        if (w_take)
            w_live_nxt[br_tag_i] = 1'b1;
        if (bru_valid_i && !bru_mispred_i)
            w_live_nxt[bru_tag_i] = 1'b0;
        if (r_state == S_RECOVER) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                if (age(ROB_W'(i), head_tag_i) >= age(r_pend_tag, head_tag_i))
                    w_live_nxt[i] = 1'b0;
        end
        if (r_state == S_FLUSH)
            w_live_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_live       <= '0;
            r_pend_tag   <= '0;
            r_cnt        <= '0;
            r_from_flush <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_live       <= w_live_nxt;
            r_pend_tag   <= w_pend_nxt;
            r_cnt        <= w_cnt_nxt;
            r_from_flush <= w_from_flush_nxt;
        end
    end

`ifdef RECOVERY_CTRL_STATS_EN
    logic [31:0] r_mispred_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispred_cnt <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_next == S_RECOVER && r_state != S_RECOVER && r_mispred_cnt != '1)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            if (w_next == S_FLUSH && r_state != S_FLUSH && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign mispred_cnt_o = r_mispred_cnt;
    assign flush_cnt_o   = r_flush_cnt;
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed-vector bench for recovery_ctrl (ROB_W=4, MAX_CKPT=4, STALL_CYCLES=2).
module tb_recovery_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  head_tag_i;
    logic        br_disp_i;
    logic [3:0]  br_tag_i;
    logic        ckpt_take_o;
    logic [3:0]  ckpt_tag_o;
    logic        dispatch_stall_o;
    logic        bru_valid_i;
    logic        bru_mispred_i;
    logic [3:0]  bru_tag_i;
    logic        exc_valid_i;
    logic        recover_o;
    logic [3:0]  recover_tag_o;
    logic        flush_o;
    logic        redirect_o;
    logic        busy_o;
`ifdef RECOVERY_CTRL_STATS_EN
    logic [31:0] mispred_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    recovery_ctrl #(
        .ROB_W        (4),
        .MAX_CKPT     (4),
        .STALL_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .head_tag_i       (head_tag_i),
        .br_disp_i        (br_disp_i),
        .br_tag_i         (br_tag_i),
        .ckpt_take_o      (ckpt_take_o),
        .ckpt_tag_o       (ckpt_tag_o),
        .dispatch_stall_o (dispatch_stall_o),
        .bru_valid_i      (bru_valid_i),
        .bru_mispred_i    (bru_mispred_i),
        .bru_tag_i        (bru_tag_i),
        .exc_valid_i      (exc_valid_i),
        .recover_o        (recover_o),
        .recover_tag_o    (recover_tag_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .busy_o           (busy_o)
`ifdef RECOVERY_CTRL_STATS_EN
        ,
        .mispred_cnt_o    (mispred_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // inputs change 1 time unit after the rising edge, checks follow
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_disp_i     = 1'b0;
        br_tag_i      = '0;
        bru_valid_i   = 1'b0;
        bru_mispred_i = 1'b0;
        bru_tag_i     = '0;
        exc_valid_i   = 1'b0;
    endtask

    task automatic grant(input logic [3:0] tag);
        br_disp_i = 1'b1;
        br_tag_i  = tag;
        #1;
        chk($sformatf("grant_take_%0d", tag), 32'(ckpt_take_o), 32'd1);
        chk($sformatf("grant_tag_%0d", tag), 32'(ckpt_tag_o), 32'(tag));
        tick();
        br_disp_i = 1'b0;
    endtask

    task automatic mispred(input logic [3:0] tag);
        bru_valid_i   = 1'b1;
        bru_mispred_i = 1'b1;
        bru_tag_i     = tag;
    endtask

    initial begin
        rst_n      = 1'b0;
        head_tag_i = '0;
        idle_inputs();
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_recover", 32'(recover_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_stall", 32'(dispatch_stall_o), 32'd0);
        chk("rst_live", 32'(dut.r_live), 32'h0000);
        #11 rst_n = 1'b1;
        tick();

        // 1: four grants fill the checkpoint pool, fifth is refused
        for (int t = 1; t <= 4; t++) grant(4'(t));
        br_disp_i = 1'b1;
        br_tag_i  = 4'd5;
        #1;
        chk("full_take", 32'(ckpt_take_o), 32'd0);
        chk("full_stall", 32'(dispatch_stall_o), 32'd1);
        tick();
        br_disp_i = 1'b0;
        chk("live_1234", 32'(dut.r_live), 32'h001E);

        // correct resolve of tag 4 leaves {1,2,3}
        bru_valid_i = 1'b1;
        bru_tag_i   = 4'd4;
        tick();
        idle_inputs();
        chk("live_123", 32'(dut.r_live), 32'h000E);

        // 2: head=0, mispredict tag 2; same-cycle dispatch must not be granted
        mispred(4'd2);
        br_disp_i = 1'b1;
        br_tag_i  = 4'd6;
        #1;
        chk("mis_blocks_take", 32'(ckpt_take_o), 32'd0);
        tick();
        idle_inputs();
        chk("t2_recover", 32'(recover_o), 32'd1);
        chk("t2_rtag", 32'(recover_tag_o), 32'd2);
        chk("t2_redirect", 32'(redirect_o), 32'd1);
        chk("t2_flush", 32'(flush_o), 32'd0);
        chk("t2_stall_n1", 32'(dispatch_stall_o), 32'd1);
        tick();
        chk("t2_live", 32'(dut.r_live), 32'h0002);
        chk("t2_rec_drop", 32'(recover_o), 32'd0);
        chk("t2_stall_n2", 32'(dispatch_stall_o), 32'd1);
        tick();
        chk("t2_stall_n3", 32'(dispatch_stall_o), 32'd1);
        tick();
        chk("t2_stall_n4", 32'(dispatch_stall_o), 32'd0);
        chk("t2_idle", 32'(busy_o), 32'd0);

        // 3: wrap, head=14, live {1,15,0}, mispredict 15 squashes all
        head_tag_i = 4'd14;
        grant(4'd15);
        grant(4'd0);
        chk("t3_live_pre", 32'(dut.r_live), 32'h8003);
        mispred(4'd15);
        tick();
        idle_inputs();
        chk("t3_recover", 32'(recover_o), 32'd1);
        chk("t3_rtag", 32'(recover_tag_o), 32'd15);
        tick();
        chk("t3_live", 32'(dut.r_live), 32'h0000);
        mispred(4'd0);
        tick();
        idle_inputs();
        chk("t3_ignored", 32'(recover_o), 32'd0);
        chk("t3_still_drain", 32'(busy_o), 32'd1);
        tick();
        chk("t3_idle", 32'(busy_o), 32'd0);

        // 4: head=3, recover 5 then an older mispredict 4 during DRAIN
        head_tag_i = 4'd3;
        mispred(4'd5);
        tick();
        idle_inputs();
        chk("t4_rtag5", 32'(recover_tag_o), 32'd5);
        tick();
        mispred(4'd4);
        tick();
        idle_inputs();
        chk("t4_recover2", 32'(recover_o), 32'd1);
        chk("t4_rtag4", 32'(recover_tag_o), 32'd4);
        tick();
        tick();
        tick();
        chk("t4_idle", 32'(busy_o), 32'd0);

        // 5: fresh reset, exception + mispredict together -> flush wins
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        head_tag_i = 4'd0;
        tick();
        grant(4'd3);
        grant(4'd7);
        chk("t5_live_pre", 32'(dut.r_live), 32'h0088);
        exc_valid_i = 1'b1;
        mispred(4'd3);
        tick();
        idle_inputs();
        chk("t5_flush", 32'(flush_o), 32'd1);
        chk("t5_recover", 32'(recover_o), 32'd0);
        chk("t5_redirect", 32'(redirect_o), 32'd1);
        tick();
        chk("t5_live", 32'(dut.r_live), 32'h0000);
        chk("t5_flush_drop", 32'(flush_o), 32'd0);
`ifdef RECOVERY_CTRL_STATS_EN
        chk("t5_flush_cnt", flush_cnt_o, 32'd1);
        chk("t5_mispred_cnt", mispred_cnt_o, 32'd0);
`endif
        tick();
        tick();
        chk("t5_idle", 32'(busy_o), 32'd0);

        // 6: async reset while in DRAIN with a live checkpoint
        grant(4'd2);
        mispred(4'd9);
        tick();
        idle_inputs();
        tick();
        chk("t6_in_drain", 32'(busy_o), 32'd1);
        chk("t6_live_pre", 32'(dut.r_live), 32'h0004);
        br_disp_i = 1'b1;
        br_tag_i  = 4'd11;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_recover", 32'(recover_o), 32'd0);
        chk("t6_flush", 32'(flush_o), 32'd0);
        chk("t6_take", 32'(ckpt_take_o), 32'd0);
        chk("t6_live", 32'(dut.r_live), 32'h0000);
        idle_inputs();
        #3 rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
